// File: rtl/vmult_pipe_if.sv
// vmult_pipe_if: operand, result and status bundle for the vmult_pipe vector multiplier.
interface vmult_pipe_if #(
   parameter int unsigned LANES = 4
) ();
   logic [16*LANES-1:0] A;
   logic [16*LANES-1:0] B;
   logic                in_valid;
   logic                in_ready;
   logic [16*LANES-1:0] product;
   logic [LANES-1:0]    Overflow;
   logic [LANES-1:0]    Underflow;
   logic                out_valid;
   logic                out_ready;
   logic                Clr_sticky;
   logic [LANES-1:0]    OvfSticky;

   modport master (
      output A, B, in_valid, out_ready, Clr_sticky,
      input  in_ready, product, Overflow, Underflow, out_valid, OvfSticky
   );

   modport slave (
      input  A, B, in_valid, out_ready, Clr_sticky,
      output in_ready, product, Overflow, Underflow, out_valid, OvfSticky
   );
endinterface

// File: rtl/vmult_pipe.sv
// vmult_pipe: LANES-wide binary16 multiplier, 3-stage pipe with whole-pipe stall and RNE rounding.
// Define VMULT_SAT_EN to saturate overflowing lanes to max finite instead of Inf.
module vmult_pipe #(
   parameter int unsigned LANES = 4
) (
   input logic         Clk2,
   input logic         Rst_n,
   vmult_pipe_if.slave bus
);

`ifdef VMULT_SAT_EN
   localparam logic [14:0] OvfMag = 15'h7BFF;
`else
   localparam logic [14:0] OvfMag = 15'h7C00;
`endif

   typedef struct packed {
      logic        sign;
      logic [6:0]  exp;
      logic [10:0] man_a;
      logic [10:0] man_b;
      logic        spec;
      logic [15:0] spec_val;
   } unp_t;

   typedef struct packed {
      logic        sign;
      logic [6:0]  exp;
      logic [21:0] prod;
      logic        spec;
      logic [15:0] spec_val;
   } mul_t;

   typedef struct packed {
      logic [15:0] res;
      logic        ovf;
      logic        unf;
   } rnd_t;

   function automatic unp_t unpack(input logic [15:0] a, input logic [15:0] b);
      unp_t       u;
      logic [4:0] ea;
      logic [4:0] eb;
      logic       za, zb, ia, ib, na, nb;
      ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      za = (a[14:0] == 15'd0);
      zb = (b[14:0] == 15'd0);
      ia = (a[14:10] == 5'h1f) && (a[9:0] == 10'd0);
      ib = (b[14:10] == 5'h1f) && (b[9:0] == 10'd0);
      na = (a[14:10] == 5'h1f) && (a[9:0] != 10'd0);
      nb = (b[14:10] == 5'h1f) && (b[9:0] != 10'd0);
      u.sign  = a[15] ^ b[15];
      u.exp   = {2'b00, ea} + {2'b00, eb} - 7'd15;
      u.man_a = {a[14:10] != 5'd0, a[9:0]};
      u.man_b = {b[14:10] != 5'd0, b[9:0]};
      u.spec  = 1'b1;
      if (na || nb || (ia && zb) || (ib && za)) begin
         u.spec_val = 16'h7E00;
      end else if (ia || ib) begin
         u.spec_val = {u.sign, 15'h7C00};
      end else if (za || zb) begin
         u.spec_val = {u.sign, 15'h0000};
      end else begin
         u.spec     = 1'b0;
         u.spec_val = 16'h0000;
      end
      return u;
   endfunction

   // Product has its hidden bit at [20]; [9] guard, [8] round, [7:0] feed sticky.
   function automatic rnd_t norm_round(input logic sign, input logic signed [6:0] exp_in,
                                       input logic [21:0] prod);
      rnd_t        o;
      logic [21:0] m;
      logic [11:0] mr;
      int          e;
      int          sh;
      logic        sticky, g, r, s, up;
      m      = prod;
      e      = int'(exp_in);
      sh     = 0;
      sticky = 1'b0;
      if (m[21]) begin
         sticky = m[0];
         m      = m >> 1;
         e      = e + 1;
      end else begin
         for (int i = 0; i < 21; i++) begin
            if (!m[20] && e > 1) begin
               m = m << 1;
               e = e - 1;
            end
         end
      end
      if (e < 1) begin
         sh = 1 - e;
         for (int i = 0; i < 22; i++) begin
            if (i < sh) begin
               sticky = sticky | m[0];
               m      = m >> 1;
            end
         end
         e = 1;
      end
      g  = m[9];
      r  = m[8];
      s  = sticky | (|m[7:0]);
      up = g & (r | s | m[10]);
      mr = {1'b0, m[20:10]} + {11'd0, up};
      if (mr[11]) begin
         mr = mr >> 1;
         e  = e + 1;
      end
      o.ovf = (e > 30);
      o.unf = ~o.ovf & ~mr[10] & (g | r | s);
      if (o.ovf) begin
         o.res = {sign, OvfMag};
      end else begin
         o.res = {sign, (mr[10] ? 5'(e) : 5'd0), mr[9:0]};
      end
      return o;
   endfunction

   logic                s1_valid_q, s1_valid_d;
   logic [16*LANES-1:0] s1_a_q, s1_a_d;
   logic [16*LANES-1:0] s1_b_q, s1_b_d;
   logic                s2_valid_q, s2_valid_d;
   unp_t [LANES-1:0]    s2_q, s2_d;
   logic                s3_valid_q, s3_valid_d;
   mul_t [LANES-1:0]    s3_q, s3_d;
   logic                out_valid_q, out_valid_d;
   logic [16*LANES-1:0] product_q, product_d;
   logic [LANES-1:0]    ovf_q, ovf_d;
   logic [LANES-1:0]    unf_q, unf_d;
   logic [LANES-1:0]    ovf_sticky_q, ovf_sticky_d;
   rnd_t [LANES-1:0]    rnd;
   logic                stall;
   logic                adv;
   logic                out_hs;

   assign stall        = out_valid_q & ~bus.out_ready;
   assign adv          = ~stall;
   assign out_hs       = out_valid_q & bus.out_ready;
   assign bus.in_ready = ~stall;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s2_valid_d = s2_valid_q;
      s2_d       = s2_q;
      s3_valid_d = s3_valid_q;
      s3_d       = s3_q;
      if (adv) begin
         s1_valid_d = bus.in_valid;
         s1_a_d     = bus.A;
         s1_b_d     = bus.B;
         s2_valid_d = s1_valid_q;
         s3_valid_d = s2_valid_q;
         for (int i = 0; i < LANES; i++) begin
            s2_d[i]          = unpack(s1_a_q[16*i +: 16], s1_b_q[16*i +: 16]);
            s3_d[i].sign     = s2_q[i].sign;
            s3_d[i].exp      = s2_q[i].exp;
            s3_d[i].prod     = {11'd0, s2_q[i].man_a} * {11'd0, s2_q[i].man_b};
            s3_d[i].spec     = s2_q[i].spec;
            s3_d[i].spec_val = s2_q[i].spec_val;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         rnd[i] = norm_round(s3_q[i].sign, s3_q[i].exp, s3_q[i].prod);
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      product_d   = product_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      if (adv) begin
         out_valid_d = s3_valid_q;
         for (int i = 0; i < LANES; i++) begin
            if (s3_q[i].spec) begin
               product_d[16*i +: 16] = s3_q[i].spec_val;
               ovf_d[i]              = 1'b0;
               unf_d[i]              = 1'b0;
            end else begin
               product_d[16*i +: 16] = rnd[i].res;
               ovf_d[i]              = rnd[i].ovf;
               unf_d[i]              = rnd[i].unf;
            end
         end
      end
   end

   // A lane overflowing on the same handshake as a clear stays set.
   always_comb begin
      ovf_sticky_d = (bus.Clr_sticky ? '0 : ovf_sticky_q) | ({LANES{out_hs}} & ovf_q);
   end

   always_ff @(posedge Clk2 or negedge Rst_n) begin
      if (!Rst_n) begin
         s1_valid_q   <= 1'b0;
         s1_a_q       <= '0;
         s1_b_q       <= '0;
         s2_valid_q   <= 1'b0;
         s2_q         <= '0;
         s3_valid_q   <= 1'b0;
         s3_q         <= '0;
         out_valid_q  <= 1'b0;
         product_q    <= '0;
         ovf_q        <= '0;
         unf_q        <= '0;
         ovf_sticky_q <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_a_q       <= s1_a_d;
         s1_b_q       <= s1_b_d;
         s2_valid_q   <= s2_valid_d;
         s2_q         <= s2_d;
         s3_valid_q   <= s3_valid_d;
         s3_q         <= s3_d;
         out_valid_q  <= out_valid_d;
         product_q    <= product_d;
         ovf_q        <= ovf_d;
         unf_q        <= unf_d;
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = unf_q;
   assign bus.OvfSticky = ovf_sticky_q;

endmodule

// File: tb/tb_vmult_pipe.sv
// tb_vmult_pipe: scoreboard bench for vmult_pipe (LANES=4) with directed lane vectors.
module tb_vmult_pipe;
   localparam int L  = 4;
   localparam int NC = 15;
`ifdef VMULT_SAT_EN
   localparam logic [15:0] OVP = 16'h7BFF;
   localparam logic [15:0] OVN = 16'hFBFF;
`else
   localparam logic [15:0] OVP = 16'h7C00;
   localparam logic [15:0] OVN = 16'hFC00;
`endif

   localparam logic [15:0] CA [NC] = '{16'h3C00, 16'hBC00, 16'h3C80, 16'h4080, 16'h4080,
      16'h3E00, 16'h3C01, 16'h7AAA, 16'h7C00, 16'hFC00, 16'h4000, 16'h4200, 16'h8000,
      16'h7E00, 16'hFAAA};
   localparam logic [15:0] CB [NC] = '{16'h3C00, 16'h3C00, 16'h0201, 16'h0011, 16'h0201,
      16'h3C01, 16'h3C01, 16'h7ADE, 16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h3C00,
      16'h3C00, 16'h7ADE};
   localparam logic [15:0] CP [NC] = '{16'h3C00, 16'hBC00, 16'h0241, 16'h0026, 16'h0482,
      16'h3E02, 16'h3C02, OVP, 16'h7E00, 16'hFC00, 16'h4400, 16'h4880, 16'h8000,
      16'h7E00, OVN};
   localparam logic CO [NC] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic CU [NC] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
      1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   typedef struct packed {
      logic [16*L-1:0] p;
      logic [L-1:0]    o;
      logic [L-1:0]    u;
   } exp_t;

   logic Clk2;
   logic Rst_n;
   exp_t sb_q[$];
   int   total;
   int   bad;
   int   n_pop;
   int   n_stall;

   vmult_pipe_if #(.LANES(L)) bus ();

   vmult_pipe #(.LANES(L)) dut (
      .Clk2  (Clk2),
      .Rst_n (Rst_n),
      .bus   (bus)
   );

   initial Clk2 = 1'b0;
   always #5 Clk2 = ~Clk2;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: compare whatever the DUT presents against the scoreboard head.
   always @(negedge Clk2) begin
      if (Rst_n && bus.out_valid) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 72'(bus.product), 72'(0));
            if (bus.product == 64'd0) begin
               bad++;
               $display("FAIL unexpected_out: out_valid=1 with no pending result");
            end
         end else begin
            chk("result", {bus.product, bus.Overflow, bus.Underflow},
                {sb_q[0].p, sb_q[0].o, sb_q[0].u});
            if (bus.out_ready) begin
               void'(sb_q.pop_front());
               n_pop++;
            end else begin
               n_stall++;
               chk("stall_in_ready", 72'(bus.in_ready), 72'(0));
            end
         end
      end
   end

   task automatic send_sel(input int c0, input int c1, input int c2, input int c3);
      int   c [L];
      int   n;
      exp_t e;
      c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
      for (int i = 0; i < L; i++) begin
         bus.A[16*i +: 16] = CA[c[i]];
         bus.B[16*i +: 16] = CB[c[i]];
         e.p[16*i +: 16]   = CP[c[i]];
         e.o[i]            = CO[c[i]];
         e.u[i]            = CU[c[i]];
      end
      bus.in_valid = 1'b1;
      n = 0;
      @(negedge Clk2);
      while (!bus.in_ready && n < 50) begin
         @(negedge Clk2);
         n++;
      end
      if (!bus.in_ready) begin
         total++;
         bad++;
         $display("FAIL send_timeout: in_ready=0 after %0d cycles, expected 1", n);
      end else begin
         sb_q.push_back(e);
      end
      @(posedge Clk2);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic send_lat(input int c0, input int c1, input int c2, input int c3);
      send_sel(c0, c1, c2, c3);
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk2);
         chk("latency", 72'(bus.out_valid), 72'(k == 3));
      end
      @(posedge Clk2);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(posedge Clk2);
         n++;
      end
      if (sb_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results pending, expected 0", sb_q.size());
         sb_q.delete();
      end
      #1;
   endtask

   task automatic pulse_clr();
      bus.Clr_sticky = 1'b1;
      @(posedge Clk2);
      #1;
      bus.Clr_sticky = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int n0;
      int s0;
      int n;
      total          = 0;
      bad            = 0;
      n_pop          = 0;
      n_stall        = 0;
      Rst_n          = 1'b0;
      bus.A          = '0;
      bus.B          = '0;
      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b1;
      bus.Clr_sticky = 1'b0;
      #2;
      chk("rst_out_valid", 72'(bus.out_valid), 72'(0));
      chk("rst_outputs", {bus.product, bus.Overflow, bus.Underflow}, 72'(0));
      chk("rst_sticky", 72'(bus.OvfSticky), 72'(0));
      #10 Rst_n = 1'b1;
      @(posedge Clk2);
      #1;
      chk("rst_in_ready", 72'(bus.in_ready), 72'(1));

      send_lat(0, 0, 0, 0);
      send_lat(1, 0, 0, 0);
      send_sel(2, 3, 4, 5);
      send_sel(6, 7, 8, 9);
      send_sel(10, 11, 12, 13);
      send_sel(14, 0, 7, 2);
      wait_drain();
      chk("sticky_accum", 72'(bus.OvfSticky), 72'(4'b0111));

      pulse_clr();
      chk("sticky_clear", 72'(bus.OvfSticky), 72'(4'b0000));
      send_sel(0, 0, 7, 0);
      wait_drain();
      chk("sticky_set", 72'(bus.OvfSticky), 72'(4'b0100));
      send_sel(0, 0, 0, 0);
      wait_drain();
      chk("sticky_hold", 72'(bus.OvfSticky), 72'(4'b0100));

      // Clear lands on the same edge as a lane-1 overflow handshake.
      send_sel(0, 7, 0, 0);
      n = 0;
      @(negedge Clk2);
      while (!bus.out_valid && n < 20) begin
         @(negedge Clk2);
         n++;
      end
      chk("set_wins_valid", 72'(bus.out_valid), 72'(1));
      bus.Clr_sticky = 1'b1;
      @(posedge Clk2);
      #1;
      bus.Clr_sticky = 1'b0;
      chk("sticky_set_wins", 72'(bus.OvfSticky), 72'(4'b0010));
      wait_drain();

      n0 = n_pop;
      s0 = n_stall;
      fork
         begin
            for (int k = 0; k < 8; k++) send_sel(k % NC, (k + 1) % NC, (k + 3) % NC, (k + 5) % NC);
         end
         begin
            repeat (4) @(posedge Clk2);
            #1 bus.out_ready = 1'b0;
            repeat (5) @(posedge Clk2);
            #1 bus.out_ready = 1'b1;
         end
      join
      wait_drain();
      chk("stream_count", 72'(n_pop - n0), 72'(8));
      chk("stall_cycles", 72'(n_stall - s0), 72'(5));

      pulse_clr();
      send_sel(7, 0, 0, 0);
      wait_drain();
      chk("sticky_pre_rst", 72'(bus.OvfSticky), 72'(4'b0001));
      send_sel(0, 1, 5, 6);
      send_sel(2, 3, 4, 10);
      send_sel(11, 12, 13, 9);
      @(posedge Clk2);
      #2;
      chk("pre_rst_valid", 72'(bus.out_valid), 72'(1));
      Rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 72'(bus.out_valid), 72'(0));
      chk("async_rst_sticky", 72'(bus.OvfSticky), 72'(0));
      sb_q.delete();
      @(posedge Clk2);
      #2 Rst_n = 1'b1;
      @(posedge Clk2);
      #1;
      send_lat(5, 6, 2, 3);
      wait_drain();
      repeat (5) @(posedge Clk2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
